// File: rtl/gc_pkg.sv
// gc_pkg: shared constants, register map and FSM encoding for the GameCube
// controller poller.
package gc_pkg;
   localparam logic [7:0] ADDR_CTRL    = 8'h00;
   localparam logic [7:0] ADDR_STATUS  = 8'h04;
   localparam logic [7:0] ADDR_DATA_HI = 8'h08;
   localparam logic [7:0] ADDR_DATA_LO = 8'h0C;

   localparam int CTRL_START  = 0;
   localparam int CTRL_RUMBLE = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_TIMEOUT = 2;

   localparam logic [23:0] POLL_CMD = 24'h400300;
   localparam int CMD_BITS = 25;
   localparam int RSP_BITS = 64;

   // Bit-cell geometry in microseconds
   localparam int CELL_US   = 4;
   localparam int LONG_US   = 3;
   localparam int SHORT_US  = 1;
   localparam int SAMPLE_US = 2;

   localparam int TMR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      TX_BIT,
      RX_WAIT,
      RX_SAMPLE,
      COMMIT
   } gc_state_t;

   // Full 25-bit poll frame: 0x40, 0x03, 0x02|rumble, then the stop bit.
   function automatic logic [CMD_BITS-1:0] poll_cmd(input logic rumble);
      return {POLL_CMD | {16'h0000, 7'h01, rumble}, 1'b1};
   endfunction
endpackage

// File: rtl/gc_apb_poller_if.sv
// gc_apb_poller_if: APB3 bus bundle between the MSS master and the poller.
interface gc_apb_poller_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/gc_bit_timer.sv
// gc_bit_timer: loadable down-counter; expire is high for the single cycle in
// which the count reaches 1, so a load of N fires N cycles after the load edge.
module gc_bit_timer
   import gc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] len,
   output logic             expire
);
   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= len;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == TMR_W'(1));
endmodule

// File: rtl/gc_apb_poller.sv
// gc_apb_poller: APB3 slave that polls a GameCube controller over its open-drain
// line, captures the 64-bit response and raises INT on completion or timeout.
module gc_apb_poller
   import gc_pkg::*;
#(
   parameter int CLK_PER_US = 10,
   parameter int TIMEOUT_US = 100
) (
   input  logic           SYSCLK,
   input  logic           SYSRESET,
   gc_apb_poller_if.slave apb,
   output logic           INT,
   input  logic           GC_DATA_IN,
   output logic           GC_DATA_OE
);
   localparam logic [TMR_W-1:0] T_CELL    = TMR_W'(CELL_US * CLK_PER_US);
   localparam logic [TMR_W-1:0] T_LONG    = TMR_W'(LONG_US * CLK_PER_US);
   localparam logic [TMR_W-1:0] T_SHORT   = TMR_W'(SHORT_US * CLK_PER_US);
   localparam logic [TMR_W-1:0] T_SAMPLE  = TMR_W'(SAMPLE_US * CLK_PER_US);
   localparam logic [TMR_W-1:0] T_TIMEOUT = TMR_W'(TIMEOUT_US * CLK_PER_US);
   localparam int TXC_W = $clog2(CMD_BITS);
   localparam int RXC_W = $clog2(RSP_BITS) + 1;

   gc_state_t state, state_nxt;

   logic                sync1, sync2, sync_prev, fall;
   logic [CMD_BITS-1:0] cmd_sr, cmd_new;
   logic [TXC_W-1:0]    tx_cnt;
   logic                tx_rel;
   logic [RSP_BITS-1:0] rx_sr;
   logic [RXC_W-1:0]    rx_cnt;
   logic [31:0]         data_hi, data_lo, rdata;
   logic                rumble, irq_en, done, timeout, busy;
   logic                acc, wr, rd, addr_ok, wr_ctrl, wr_stat, start;
   logic                bt_load, bt_exp, to_load, to_exp;
   logic [TMR_W-1:0]    bt_len;
   logic                tx_to_rel, tx_next, rx_shift, do_commit, do_timeout;
   logic                unused_pwdata;

   function automatic logic [TMR_W-1:0] low_len(input logic b);
      return b ? T_SHORT : T_LONG;
   endfunction

   gc_bit_timer u_bit_tmr (
      .clk(SYSCLK), .rst(SYSRESET), .load(bt_load), .len(bt_len), .expire(bt_exp)
   );
   gc_bit_timer u_to_tmr (
      .clk(SYSCLK), .rst(SYSRESET), .load(to_load), .len(T_TIMEOUT), .expire(to_exp)
   );

   // Line input is asynchronous: two-flop synchronizer plus one history flop.
   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync1     <= GC_DATA_IN;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end
   assign fall = sync_prev & ~sync2;

   assign acc     = apb.PSEL & apb.PENABLE;
   assign wr      = acc & apb.PWRITE;
   assign rd      = acc & ~apb.PWRITE;
   assign wr_ctrl = wr & (apb.PADDR == ADDR_CTRL);
   assign wr_stat = wr & (apb.PADDR == ADDR_STATUS);
   assign busy    = (state != IDLE);
   assign start   = wr_ctrl & apb.PWDATA[CTRL_START] & ~busy;
   assign cmd_new = poll_cmd(apb.PWDATA[CTRL_RUMBLE]);
   assign unused_pwdata = ^apb.PWDATA[31:3];

   always_comb begin
      rdata   = '0;
      addr_ok = 1'b1;
      case (apb.PADDR)
         ADDR_CTRL: begin
            rdata[CTRL_RUMBLE] = rumble;
            rdata[CTRL_IRQ_EN] = irq_en;
         end
         ADDR_STATUS: begin
            rdata[ST_BUSY]    = busy;
            rdata[ST_DONE]    = done;
            rdata[ST_TIMEOUT] = timeout;
         end
         ADDR_DATA_HI: rdata = data_hi;
         ADDR_DATA_LO: rdata = data_lo;
         default:      addr_ok = 1'b0;
      endcase
   end

   assign apb.PRDATA  = (rd && addr_ok) ? rdata : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = acc & ~addr_ok;

   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      bt_load    = 1'b0;
      bt_len     = '0;
      to_load    = 1'b0;
      tx_to_rel  = 1'b0;
      tx_next    = 1'b0;
      rx_shift   = 1'b0;
      do_commit  = 1'b0;
      do_timeout = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nxt = TX_BIT;
            bt_load   = 1'b1;
            bt_len    = low_len(cmd_new[CMD_BITS-1]);
         end
         // Each cell is a driven-low phase followed by a released phase.
         TX_BIT: if (bt_exp) begin
            if (!tx_rel) begin
               tx_to_rel = 1'b1;
               bt_load   = 1'b1;
               bt_len    = T_CELL - low_len(cmd_sr[CMD_BITS-1]);
            end else if (tx_cnt == TXC_W'(CMD_BITS - 1)) begin
               state_nxt = RX_WAIT;
               to_load   = 1'b1;
            end else begin
               tx_next = 1'b1;
               bt_load = 1'b1;
               bt_len  = low_len(cmd_sr[CMD_BITS-2]);
            end
         end
         RX_WAIT: if (fall) begin
            state_nxt = RX_SAMPLE;
            bt_load   = 1'b1;
            bt_len    = T_SAMPLE;
            to_load   = 1'b1;
         end else if (to_exp) begin
            state_nxt  = IDLE;
            do_timeout = 1'b1;
         end
         RX_SAMPLE: if (bt_exp) begin
            rx_shift  = 1'b1;
            state_nxt = (rx_cnt == RXC_W'(RSP_BITS - 1)) ? COMMIT : RX_WAIT;
         end
         COMMIT: begin
            do_commit = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Later assignments win: hardware set of DONE/TIMEOUT beats a same-cycle W1C.
   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         cmd_sr  <= '0;
         tx_cnt  <= '0;
         tx_rel  <= 1'b0;
         rx_sr   <= '0;
         rx_cnt  <= '0;
         data_hi <= '0;
         data_lo <= '0;
         rumble  <= 1'b0;
         irq_en  <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         INT     <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            rumble <= apb.PWDATA[CTRL_RUMBLE];
            irq_en <= apb.PWDATA[CTRL_IRQ_EN];
         end
         if (wr_stat && apb.PWDATA[ST_DONE])    done    <= 1'b0;
         if (wr_stat && apb.PWDATA[ST_TIMEOUT]) timeout <= 1'b0;
         if (start) begin
            cmd_sr  <= cmd_new;
            tx_cnt  <= '0;
            tx_rel  <= 1'b0;
            rx_cnt  <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
         end
         if (tx_to_rel) tx_rel <= 1'b1;
         if (tx_next) begin
            tx_rel <= 1'b0;
            cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
            tx_cnt <= tx_cnt + 1'b1;
         end
         if (rx_shift) begin
            rx_sr  <= {rx_sr[RSP_BITS-2:0], sync2};
            rx_cnt <= rx_cnt + 1'b1;
         end
         if (do_commit) begin
            data_hi <= rx_sr[63:32];
            data_lo <= rx_sr[31:0];
            done    <= 1'b1;
         end
         if (do_timeout) timeout <= 1'b1;
         INT <= irq_en & (done | timeout);
      end
   end

   assign GC_DATA_OE = (state == TX_BIT) & ~tx_rel;
endmodule

// File: tb/tb_gc_apb_poller.sv
// tb_gc_apb_poller: randomized poll/response scenarios against a timing and
// register model of the controller poller.
module tb_gc_apb_poller;
   localparam int PER = 10;
   localparam int US  = 10;
   localparam int TO_US = 100;

   logic clk, rst, irq, oe, gc_in, ctl_low;
   int checks, failures;
   logic [31:0] exp_hi, exp_lo;

   gc_apb_poller_if apb ();

   assign gc_in = ~(oe | ctl_low);

   gc_apb_poller #(.CLK_PER_US(US), .TIMEOUT_US(TO_US)) dut (
      .SYSCLK(clk), .SYSRESET(rst), .apb(apb), .INT(irq),
      .GC_DATA_IN(gc_in), .GC_DATA_OE(oe)
   );

   initial clk = 1'b0;
   always #(PER/2) clk = ~clk;

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      #1;
      d = apb.PRDATA; e = apb.PSLVERR;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   // Controller model: bit 1 = low 1 us, bit 0 = low 3 us, 4 us per cell.
   task automatic ctl_send(input logic [63:0] r, input int nbits, input bit stop);
      int lo;
      for (int i = 0; i < nbits; i++) begin
         lo = r[63-i] ? US : 3*US;
         ctl_low = 1'b1; repeat (lo) @(negedge clk);
         ctl_low = 1'b0; repeat (4*US - lo) @(negedge clk);
      end
      if (stop) begin
         ctl_low = 1'b1; repeat (US) @(negedge clk);
         ctl_low = 1'b0; repeat (3*US) @(negedge clk);
      end
   endtask

   // Watches all 25 command cells on OE; s0 is the time OE was first seen low-driving.
   task automatic capture_tx(input logic [24:0] cmd, output time s0);
      int n, w, g, per;
      logic prev;
      time last_t;
      n = 0; w = 0; g = 0; prev = 1'b0; s0 = 0; last_t = 0;
      while (n < 25 && g < 3000) begin
         @(negedge clk); g++;
         if (oe && !prev) begin
            if (n == 0) s0 = $time;
            else begin
               per = int'(($time - last_t) / PER);
               checks++;
               if (per != 4*US) begin
                  failures++;
                  $display("FAIL tx_cell_period cell=%0d got=%0d exp=%0d", n, per, 4*US);
               end
            end
            last_t = $time; w = 0;
         end
         if (oe) w++;
         if (!oe && prev) begin
            checks++;
            if (w != (cmd[24-n] ? US : 3*US)) begin
               failures++;
               $display("FAIL tx_pulse cell=%0d got=%0d exp=%0d", n, w, cmd[24-n] ? US : 3*US);
            end
            n++;
         end
         prev = oe;
      end
      checks++;
      if (n != 25) begin
         failures++;
         $display("FAIL tx_cell_count got=%0d exp=25", n);
      end
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e;
      rst = 1'b1; ctl_low = 1'b0;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (oe !== 1'b0 || irq !== 1'b0) begin
         failures++; $display("FAIL reset_pins oe=%b int=%b exp=0/0", oe, irq);
      end
      for (int i = 0; i < 4; i++) begin
         apb_read(8'(4*i), d, e);
         checks++;
         if (d !== 32'h0 || e !== 1'b0) begin
            failures++; $display("FAIL reset_read addr=%0h got=%h err=%b exp=0/0", 4*i, d, e);
         end
      end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_bad_addr;
      logic [31:0] d; logic e;
      apb_read(8'h10, d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
         failures++; $display("FAIL bad_addr_read got=%h err=%b exp=0/1", d, e);
      end
      apb_write(8'h10, 32'hFFFF_FFFF);
      apb_read(8'h00, d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b0 || oe !== 1'b0) begin
         failures++; $display("FAIL bad_addr_side_effect ctrl=%h err=%b oe=%b exp=0/0/0", d, e, oe);
      end
   endtask

   task automatic test_poll(input logic [63:0] rsp, input logic rum, input bit busy_start);
      logic [24:0] cmd; logic [31:0] d; logic e; time s0; bit saw;
      cmd = {16'h4003, 8'h02 | {7'd0, rum}, 1'b1};
      fork
         capture_tx(cmd, s0);
         begin
            apb_write(8'h00, {29'd0, 1'b1, rum, 1'b1});
            repeat (200) @(negedge clk);
            apb_read(8'h04, d, e);
            checks++;
            if (d !== 32'h1) begin
               failures++; $display("FAIL busy_during_tx got=%h exp=00000001", d);
            end
            if (busy_start) apb_write(8'h00, {29'd0, 1'b1, ~rum, 1'b1});
         end
      join
      repeat ($urandom_range(40, 80)) @(negedge clk);
      ctl_send(rsp, 64, 1'b1);
      repeat (5) @(negedge clk);
      exp_hi = rsp[63:32]; exp_lo = rsp[31:0];
      apb_read(8'h08, d, e);
      checks++;
      if (d !== exp_hi) begin failures++; $display("FAIL data_hi got=%h exp=%h", d, exp_hi); end
      apb_read(8'h0C, d, e);
      checks++;
      if (d !== exp_lo) begin failures++; $display("FAIL data_lo got=%h exp=%h", d, exp_lo); end
      apb_read(8'h04, d, e);
      checks++;
      if (d !== 32'h2 || irq !== 1'b1) begin
         failures++; $display("FAIL done_status got=%h int=%b exp=00000002/1", d, irq);
      end
      apb_write(8'h04, 32'h2);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL int_w1c_lag got=%b exp=1", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL int_w1c_drop got=%b exp=0", irq); end
      if (busy_start) begin
         saw = 1'b0;
         repeat (1100) begin @(negedge clk); if (oe) saw = 1'b1; end
         apb_read(8'h04, d, e);
         checks++;
         if (saw || d !== 32'h0) begin
            failures++; $display("FAIL single_completion oe_seen=%b status=%h exp=0/0", saw, d);
         end
      end
   endtask

   task automatic test_timeout;
      logic [31:0] d; logic e; time s0; int g, el; logic rum;
      rum = 1'($urandom);
      fork
         capture_tx({16'h4003, 8'h02 | {7'd0, rum}, 1'b1}, s0);
         apb_write(8'h00, {29'd0, 1'b1, rum, 1'b1});
      join
      g = 0;
      while (!irq && g < 4000) begin @(negedge clk); g++; end
      el = int'(($time - s0) / PER);
      checks++;
      if (el != 25*4*US + TO_US*US + 1) begin
         failures++; $display("FAIL timeout_latency got=%0d exp=%0d", el, 25*4*US + TO_US*US + 1);
      end
      apb_read(8'h04, d, e);
      checks++;
      if (d !== 32'h4) begin failures++; $display("FAIL timeout_status got=%h exp=00000004", d); end
      apb_read(8'h08, d, e);
      checks++;
      if (d !== exp_hi) begin failures++; $display("FAIL timeout_data_hi got=%h exp=%h", d, exp_hi); end
      apb_read(8'h0C, d, e);
      checks++;
      if (d !== exp_lo) begin failures++; $display("FAIL timeout_data_lo got=%h exp=%h", d, exp_lo); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic e; time s0;
      apb_write(8'h00, 32'h5);
      checks++;
      if (oe !== 1'b1) begin failures++; $display("FAIL tx_started got=%b exp=1", oe); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (oe !== 1'b0) begin failures++; $display("FAIL reset_mid_tx_oe got=%b exp=0", oe); end
      @(negedge clk); rst = 1'b0;
      apb_read(8'h04, d, e);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_tx_status got=%h exp=0", d); end
      fork
         capture_tx({16'h4003, 8'h02, 1'b1}, s0);
         apb_write(8'h00, 32'h5);
      join
      repeat (40) @(negedge clk);
      ctl_send({$urandom, $urandom}, 20, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (oe !== 1'b0 || irq !== 1'b0) begin
         failures++; $display("FAIL reset_mid_rx_pins oe=%b int=%b exp=0/0", oe, irq);
      end
      @(negedge clk); rst = 1'b0;
      exp_hi = '0; exp_lo = '0;
      apb_read(8'h04, d, e);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_rx_status got=%h exp=0", d); end
      apb_read(8'h08, d, e);
      checks++;
      if (d !== exp_hi) begin failures++; $display("FAIL reset_mid_rx_data got=%h exp=%h", d, exp_hi); end
   endtask

   initial begin
      checks = 0; failures = 0;
      test_reset;
      test_bad_addr;
      test_poll(64'h0080_8080_8080_0000, 1'b0, 1'b0);
      test_timeout;
      test_poll({$urandom, $urandom}, 1'($urandom), 1'b1);
      test_reset_mid;
      test_poll({$urandom, $urandom}, 1'($urandom), 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gc_apb_poller.md
Name: gc_apb_poller

Overview:
- APB3 slave peripheral in the FPGA fabric, directly downstream of the MSS APB master port.
- Polls a GameCube controller over the single-wire open-drain bus and captures the 64-bit status response.
- Exposes control, status and data registers to the Cortex-M3.
- Drives the MSS fabric interrupt (FABINT) when a poll completes or times out.

Parameters:
- CLK_PER_US, 10, fabric clock cycles per microsecond (10 MHz FAB_CLK).
- TIMEOUT_US, 100, microseconds without a falling edge after which a pending response aborts.

Ports:
- SYSCLK  in  1  fabric clock (FAB_CLK).
- SYSRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready; tied to 1.
- PSLVERR  out  1  APB error.
- INT  out  1  level interrupt to FABINT.
- GC_DATA_IN  in  1  controller line, asynchronous.
- GC_DATA_OE  out  1  1 = pull line low; 0 = release line.

Behaviour:
- Reset: PRDATA=0, PSLVERR=0, INT=0, GC_DATA_OE=0, all registers 0, FSM=IDLE.
- A reset mid-transfer releases the line immediately.

Register map (write on PSEL&PENABLE&PWRITE; read data driven combinationally in the access phase):
- 0x00 CTRL:
  - bit0 START: write-1 pulse, reads 0.
  - bit1 RUMBLE.
  - bit2 IRQ_EN.
- 0x04 STATUS:
  - bit0 BUSY: read-only.
  - bit1 DONE: write-1-to-clear.
  - bit2 TIMEOUT: write-1-to-clear.
- 0x08 DATA_HI = response[63:32]; 0x0C DATA_LO = response[31:0]. Both read-only.
- Any other address: PRDATA=0, PSLVERR=1 in the access phase, no side effects.

Start rules:
- START while BUSY is ignored.
- START while idle clears DONE and TIMEOUT, loads the command and sets BUSY the next cycle.
- Command (25 bits, MSB first): 0x4003, then 0x02|RUMBLE, then stop bit 1.

Input path:
- GC_DATA_IN passes a 2-flop synchronizer.
- Falling edge = synchronized previous 1, current 0.

FSM states:
- IDLE: GC_DATA_OE=0.
- TX_BIT: each bit cell is 4*CLK_PER_US cycles.
  - Bit 0: OE=1 for 3 us, then 0 for 1 us.
  - Bit 1: OE=1 for 1 us, then 0 for 3 us.
  - After 25 cells go to RX_WAIT.
- RX_WAIT: wait for a falling edge.
  - Timeout counter counts to TIMEOUT_US*CLK_PER_US.
  - On expiry: set TIMEOUT, clear BUSY, go to IDLE.
  - On a falling edge: go to RX_SAMPLE. The timeout counter resets on every falling edge.
- RX_SAMPLE: 2*CLK_PER_US cycles after the edge, shift the synchronized line into a 64-bit shift register (MSB first).
  - If 64 bits have been received, go to COMMIT; otherwise return to RX_WAIT.
- COMMIT: copy the shift register to DATA_HI/DATA_LO, set DONE, clear BUSY, go to IDLE.
  - The controller stop bit that follows is ignored; its falling edge arrives while in IDLE.

Data and interrupt:
- DATA registers change only in COMMIT. Reads during BUSY return the previous poll.
- Timeout leaves DATA unchanged.
- INT is registered: INT <= IRQ_EN & (DONE|TIMEOUT).
- Simultaneous W1C of DONE and COMMIT in the same cycle: set wins.

Decomposition:
- Shared package gc_pkg:
  - Register offsets.
  - CTRL/STATUS bit indices.
  - Poll command constant 24'h400300.
  - FSM state enum.
  - Bit-cell lengths in us (4/3/1/2).
- Sub-module gc_bit_timer: down-counter loaded with a cycle count, produces a one-cycle expiry pulse. Instantiated once for bit timing and once for the timeout.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C -> all read 0; PSLVERR=0; GC_DATA_OE=0; INT=0.
- Write CTRL=0x1 with RUMBLE=0 -> first OE low pulse lasts 30 cycles (bit0=0), second lasts 10 cycles (bit1=1); 25 cells total = 1000 cycles; BUSY=1 throughout.
- After TX, a controller model sends 64'h0080_8080_8080_0000 plus stop bit -> DATA_HI=0x00808080, DATA_LO=0x80800000, STATUS=0x2; with IRQ_EN=1, INT=1; writing STATUS=0x2 drops INT one cycle later.
- Write CTRL=0x5 and the controller stays silent -> TIMEOUT set 1000 cycles after TX ends; STATUS=0x4; INT=1; DATA unchanged from the prior poll.
- Write START again while BUSY=1 -> TX sequence unaltered; single completion.
- Read 0x10 -> PRDATA=0, PSLVERR=1. Assert SYSRESET mid-RX -> OE=0 and BUSY=0 immediately; a new START then completes normally.
